seg7_capture: RTL and testbench
===============================

Name: seg7_capture

Overview:
- Inverse of the board's hex-to-7-segment decoder: samples an active-low 7-segment pattern bus and recovers the 4-bit hex digit it shows.
- Used as an on-chip display monitor and self-check path, so the seven-segment bus a CPU drives can be read back as nibbles.
- Output is emitted only after the pattern has been stable for a programmable run length.
- Results are delivered through a single-entry valid/ready buffer with a saturating drop counter.

Parameters:
- STABLE_CYCLES, 4: consecutive qualified samples of an identical pattern required before an event is emitted (legal range 1..255).
- DROP_W, 8: width of the dropped-event counter.

Ports:
- clk  input  1  system clock; all logic on the rising edge
- reset  input  1  synchronous, active-high reset
- seg_n  input  7  segment pattern, bit 0 = segment a … bit 6 = segment g; active-low (0 = lit)
- seg_valid  input  1  qualifies seg_n this cycle
- out_valid  output  1  event buffer holds an event
- out_ready  input  1  consumer accepts the event when out_valid && out_ready
- out_value  output  4  decoded hex digit; 0 when out_blank or out_err
- out_blank  output  1  event was the all-off pattern 7'h7F
- out_err  output  1  event was a pattern outside the glyph table and not blank
- drop_count  output  DROP_W  events lost because the buffer was full; saturates at all-ones

Behaviour:
- Glyph table (seg_n → value):
  - 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 58→7
  - 00→8, 10→9, 08→A, 03→b, 46→C, 21→d, 06→E, 0E→F
  - 7F→blank; any other code → err.
- Reset: last_seg=7'h7F, run_cnt=0, buffer EMPTY, out_valid=0, out_value=0, out_blank=0, out_err=0, drop_count=0.
- Run tracker (only on cycles with seg_valid=1; seg_valid=0 holds all tracker state):
  - seg_n != last_seg: last_seg<=seg_n, run_cnt<=1.
  - seg_n == last_seg: run_cnt<=min(run_cnt+1, STABLE_CYCLES).
  - Emit event when next run_cnt == STABLE_CYCLES and current run_cnt != STABLE_CYCLES. Exactly one event per run; a run ends only on a differing valid sample.
  - With STABLE_CYCLES=1, every differing sample emits.
  - A steady 7F after reset emits one blank event once the run completes.
- Event contents: decode of the sample that completed the run.
- Latency: out_valid rises on the cycle after the STABLE_CYCLES-th qualifying sample.
- Output buffer FSM, EMPTY/FULL:
  - EMPTY + emit → FULL, load fields.
  - FULL + handshake, no emit → EMPTY.
  - FULL + handshake + emit same cycle → stays FULL with the new event loaded; no drop.
  - FULL + emit, no handshake → event discarded, buffer unchanged, drop_count+1 (saturating).
  - Fields and out_valid are stable while FULL and not accepted.
- out_ready is ignored while EMPTY.
- out_value/out_blank/out_err are registered; they hold their last value after acceptance and are meaningful only while out_valid=1.
- Reset asserted mid-run or with the buffer FULL clears everything on that edge. The pending event is lost and not counted as a drop. The first post-reset sample starts a new run, or extends the reset value 7F.

Test Plan:
- STABLE_CYCLES=4, out_ready=1, seg_n=7'h24 for 4 valid cycles → out_valid high for 1 cycle on cycle 5 with out_value=2, blank=0, err=0. Holding 24 for 20 more cycles → no further events.
- Sweep all 16 glyphs plus 7F and 7'h7E, each for 4 cycles → values 0..F in order, then a blank event, then an err event with out_value=0.
- Present 58 for 3 cycles, 00 for 1 cycle, then 58 for 4 cycles → only one event: value 7. Repeat the 58 run with seg_valid toggling 0/1 → the event fires after the 4th qualified sample.
- out_ready=0; emit 3 distinct digits 1, 2, 3 → buffer holds 1 and drop_count=2. Raise out_ready on the cycle digit 4 completes → 1 accepted, 4 loaded, drop_count stays 2.
- DROP_W=2, 5 drops with out_ready=0 → drop_count=3 (saturated).
- Buffer FULL with 9 plus a run in progress; assert reset for 1 cycle → all outputs 0 next cycle. Re-present 9 → a new event only after 4 fresh samples.

Source files
------------

// File: rtl/seg7_capture_if.sv
// seg7_capture_if: bundles the segment sample bus and the event output
// handshake of seg7_capture.
//   seg_n, seg_valid        : active-low segment pattern and its qualifier
//   out_valid, out_ready    : event buffer handshake
//   out_value, out_blank,
//   out_err                 : decoded event fields
//   drop_count              : saturating count of events lost to a full buffer
// Modports: slave = capture block view, master = producer/consumer view.
interface seg7_capture_if #(
    parameter int unsigned DROP_W = 8
);
    logic [6:0]        seg_n;
    logic              seg_valid;
    logic              out_valid;
    logic              out_ready;
    logic [3:0]        out_value;
    logic              out_blank;
    logic              out_err;
    logic [DROP_W-1:0] drop_count;

    modport slave (
        input  seg_n, seg_valid, out_ready,
        output out_valid, out_value, out_blank, out_err, drop_count
    );

    modport master (
        output seg_n, seg_valid, out_ready,
        input  out_valid, out_value, out_blank, out_err, drop_count
    );
endinterface

// File: rtl/seg7_capture.sv
// seg7_capture: reads back an active-low 7-segment pattern bus as a hex nibble.
// A pattern must be seen on STABLE_CYCLES consecutive qualified samples before
// one event is emitted; events go through a single-entry valid/ready buffer and
// events arriving while it is full are counted in a saturating drop counter.
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : seg7_capture_if.slave (pattern input, event output, drop_count)
module seg7_capture #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned DROP_W        = 8
) (
    input  logic            clk,
    input  logic            reset,
    seg7_capture_if.slave   bus
);
    localparam logic [7:0] RUN_MAX = 8'(STABLE_CYCLES);

    typedef enum logic {
        EMPTY,
        FULL
    } buf_state_t;

    // Returns {blank, err, value}.
    function automatic logic [5:0] decode(input logic [6:0] p);
        logic [5:0] r;
        r = 6'b01_0000;
        case (p)
            7'h40: r = {2'b00, 4'h0};
            7'h79: r = {2'b00, 4'h1};
            7'h24: r = {2'b00, 4'h2};
            7'h30: r = {2'b00, 4'h3};
            7'h19: r = {2'b00, 4'h4};
            7'h12: r = {2'b00, 4'h5};
            7'h02: r = {2'b00, 4'h6};
            7'h58: r = {2'b00, 4'h7};
            7'h00: r = {2'b00, 4'h8};
            7'h10: r = {2'b00, 4'h9};
            7'h08: r = {2'b00, 4'hA};
            7'h03: r = {2'b00, 4'hB};
            7'h46: r = {2'b00, 4'hC};
            7'h21: r = {2'b00, 4'hD};
            7'h06: r = {2'b00, 4'hE};
            7'h0E: r = {2'b00, 4'hF};
            7'h7F: r = {2'b10, 4'h0};
            default: r = 6'b01_0000;
        endcase
        return r;
    endfunction

    logic [6:0]        last_seg;
    logic [7:0]        run_cnt;
    logic [7:0]        cnt_next;
    logic              same;
    logic              emit;
    logic [5:0]        dec;

    buf_state_t        state_q, state_d;
    logic              load;
    logic              drop;
    logic [3:0]        value_q;
    logic              blank_q;
    logic              err_q;
    logic [DROP_W-1:0] drop_q;

    assign dec = decode(bus.seg_n);

    // A differing sample starts a new run, so it may emit on its own when
    // STABLE_CYCLES is 1 even though the previous run had already completed.
    always_comb begin
        same     = (bus.seg_n == last_seg);
        cnt_next = run_cnt;
        emit     = 1'b0;
        if (bus.seg_valid) begin
            if (!same) begin
                cnt_next = 8'd1;
            end else if (run_cnt != RUN_MAX) begin
                cnt_next = run_cnt + 8'd1;
            end
            emit = (cnt_next == RUN_MAX) && (!same || (run_cnt != RUN_MAX));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_seg <= 7'h7F;
            run_cnt  <= '0;
        end else if (bus.seg_valid) begin
            last_seg <= bus.seg_n;
            run_cnt  <= cnt_next;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        drop    = 1'b0;
        case (state_q)
            EMPTY: begin
                if (emit) begin
                    state_d = FULL;
                    load    = 1'b1;
                end
            end
            FULL: begin
                if (bus.out_ready) begin
                    // Acceptance frees the slot for a same-cycle event.
                    if (emit) begin
                        load = 1'b1;
                    end else begin
                        state_d = EMPTY;
                    end
                end else if (emit) begin
                    drop = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            value_q <= '0;
            blank_q <= 1'b0;
            err_q   <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                blank_q <= dec[5];
                err_q   <= dec[4];
                value_q <= dec[3:0];
            end
            if (drop && (drop_q != '1)) begin
                drop_q <= drop_q + 1'b1;
            end
        end
    end

    assign bus.out_valid  = (state_q == FULL);
    assign bus.out_value  = value_q;
    assign bus.out_blank  = blank_q;
    assign bus.out_err    = err_q;
    assign bus.drop_count = drop_q;
endmodule

// File: tb/tb_seg7_capture.sv
// tb_seg7_capture: directed bench for seg7_capture. A glyph sweep is driven
// from a vector table; run, handshake, drop and reset corner cases are
// hand-written sequences. A second instance with DROP_W=2 shares the stimulus
// to exercise counter saturation.
module tb_seg7_capture;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    seg7_capture_if #(.DROP_W(8)) b1 ();
    seg7_capture_if #(.DROP_W(2)) b2 ();

    seg7_capture #(.STABLE_CYCLES(4), .DROP_W(8)) u1 (
        .clk   (clk),
        .reset (rst),
        .bus   (b1.slave)
    );

    seg7_capture #(.STABLE_CYCLES(4), .DROP_W(2)) u2 (
        .clk   (clk),
        .reset (rst),
        .bus   (b2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] seg;
        logic [3:0] exp_value;
        logic       exp_blank;
        logic       exp_err;
    } vec_t;

    vec_t vecs [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs to both instances, then sample 1ns after the edge.
    task automatic step(input logic [6:0] s, input logic v, input logic r);
        b1.seg_n     = s;
        b1.seg_valid = v;
        b1.out_ready = r;
        b2.seg_n     = s;
        b2.seg_valid = v;
        b2.out_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(7'h7F, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic run(input logic [6:0] s, input int unsigned n, input logic r);
        for (int unsigned i = 0; i < n; i++) step(s, 1'b1, r);
    endtask

    initial begin
        int unsigned nvalid;
        total = 0;
        bad   = 0;
        rst   = 1'b1;

        vecs[0]  = '{7'h40, 4'h0, 1'b0, 1'b0};
        vecs[1]  = '{7'h79, 4'h1, 1'b0, 1'b0};
        vecs[2]  = '{7'h24, 4'h2, 1'b0, 1'b0};
        vecs[3]  = '{7'h30, 4'h3, 1'b0, 1'b0};
        vecs[4]  = '{7'h19, 4'h4, 1'b0, 1'b0};
        vecs[5]  = '{7'h12, 4'h5, 1'b0, 1'b0};
        vecs[6]  = '{7'h02, 4'h6, 1'b0, 1'b0};
        vecs[7]  = '{7'h58, 4'h7, 1'b0, 1'b0};
        vecs[8]  = '{7'h00, 4'h8, 1'b0, 1'b0};
        vecs[9]  = '{7'h10, 4'h9, 1'b0, 1'b0};
        vecs[10] = '{7'h08, 4'hA, 1'b0, 1'b0};
        vecs[11] = '{7'h03, 4'hB, 1'b0, 1'b0};
        vecs[12] = '{7'h46, 4'hC, 1'b0, 1'b0};
        vecs[13] = '{7'h21, 4'hD, 1'b0, 1'b0};
        vecs[14] = '{7'h06, 4'hE, 1'b0, 1'b0};
        vecs[15] = '{7'h0E, 4'hF, 1'b0, 1'b0};
        vecs[16] = '{7'h7F, 4'h0, 1'b1, 1'b0};
        vecs[17] = '{7'h7E, 4'h0, 1'b0, 1'b1};

        // Reset state
        do_reset();
        chk("rst_valid", 32'(b1.out_valid), 32'd0);
        chk("rst_value", 32'(b1.out_value), 32'd0);
        chk("rst_blank", 32'(b1.out_blank), 32'd0);
        chk("rst_err",   32'(b1.out_err),   32'd0);
        chk("rst_drop",  32'(b1.drop_count), 32'd0);

        // Basic run of digit 2 with latency check, then a long hold
        for (int unsigned i = 0; i < 3; i++) begin
            step(7'h24, 1'b1, 1'b1);
            chk("d2_early_valid", 32'(b1.out_valid), 32'd0);
        end
        step(7'h24, 1'b1, 1'b1);
        chk("d2_valid", 32'(b1.out_valid), 32'd1);
        chk("d2_value", 32'(b1.out_value), 32'd2);
        chk("d2_blank", 32'(b1.out_blank), 32'd0);
        chk("d2_err",   32'(b1.out_err),   32'd0);
        nvalid = 0;
        for (int unsigned i = 0; i < 20; i++) begin
            step(7'h24, 1'b1, 1'b1);
            if (b1.out_valid) nvalid++;
        end
        chk("d2_hold_no_events", 32'(nvalid), 32'd0);

        // Table-driven glyph sweep
        do_reset();
        for (int unsigned k = 0; k < 18; k++) begin
            run(vecs[k].seg, 3, 1'b1);
            chk("sweep_early_valid", 32'(b1.out_valid), 32'd0);
            step(vecs[k].seg, 1'b1, 1'b1);
            chk("sweep_valid", 32'(b1.out_valid), 32'd1);
            chk("sweep_value", 32'(b1.out_value), 32'(vecs[k].exp_value));
            chk("sweep_blank", 32'(b1.out_blank), 32'(vecs[k].exp_blank));
            chk("sweep_err",   32'(b1.out_err),   32'(vecs[k].exp_err));
        end

        // Interrupted run: 58 x3, 00 x1, 58 x4 -> exactly one event (7)
        do_reset();
        nvalid = 0;
        for (int unsigned i = 0; i < 8; i++) begin
            step((i == 3) ? 7'h00 : 7'h58, 1'b1, 1'b1);
            if (b1.out_valid) nvalid++;
        end
        chk("intr_valid_last", 32'(b1.out_valid), 32'd1);
        chk("intr_value", 32'(b1.out_value), 32'd7);
        chk("intr_event_count", 32'(nvalid), 32'd1);

        // Qualifier toggling: unqualified samples carry a different pattern
        do_reset();
        for (int unsigned i = 0; i < 7; i++) begin
            step((i % 2 == 0) ? 7'h58 : 7'h00, (i % 2 == 0), 1'b1);
            if (i < 6) chk("tog_early_valid", 32'(b1.out_valid), 32'd0);
        end
        chk("tog_valid", 32'(b1.out_valid), 32'd1);
        chk("tog_value", 32'(b1.out_value), 32'd7);

        // Back-pressure: 1 held, 2 and 3 dropped; 4 completes with handshake
        do_reset();
        run(7'h79, 4, 1'b0);
        run(7'h24, 4, 1'b0);
        run(7'h30, 4, 1'b0);
        chk("bp_valid", 32'(b1.out_valid), 32'd1);
        chk("bp_value", 32'(b1.out_value), 32'd1);
        chk("bp_drop",  32'(b1.drop_count), 32'd2);
        chk("bp_drop_w2", 32'(b2.drop_count), 32'd2);
        run(7'h19, 3, 1'b0);
        chk("bp_value_hold", 32'(b1.out_value), 32'd1);
        step(7'h19, 1'b1, 1'b1);
        chk("bp_swap_valid", 32'(b1.out_valid), 32'd1);
        chk("bp_swap_value", 32'(b1.out_value), 32'd4);
        chk("bp_swap_drop",  32'(b1.drop_count), 32'd2);
        step(7'h19, 1'b1, 1'b1);
        chk("bp_accept_empty", 32'(b1.out_valid), 32'd0);
        chk("bp_accept_value_held", 32'(b1.out_value), 32'd4);

        // Saturation: 6 events with no consumer -> 5 drops
        do_reset();
        run(7'h79, 4, 1'b0);
        run(7'h24, 4, 1'b0);
        run(7'h30, 4, 1'b0);
        run(7'h19, 4, 1'b0);
        run(7'h12, 4, 1'b0);
        run(7'h02, 4, 1'b0);
        chk("sat_drop_w8", 32'(b1.drop_count), 32'd5);
        chk("sat_drop_w2", 32'(b2.drop_count), 32'd3);
        chk("sat_value", 32'(b2.out_value), 32'd1);

        // Reset with buffer full and a run in progress
        do_reset();
        run(7'h10, 4, 1'b0);
        chk("rf_value", 32'(b1.out_value), 32'd9);
        run(7'h00, 2, 1'b0);
        rst = 1'b1;
        step(7'h00, 1'b1, 1'b0);
        rst = 1'b0;
        chk("rf_valid", 32'(b1.out_valid), 32'd0);
        chk("rf_value0", 32'(b1.out_value), 32'd0);
        chk("rf_blank", 32'(b1.out_blank), 32'd0);
        chk("rf_err", 32'(b1.out_err), 32'd0);
        chk("rf_drop", 32'(b1.drop_count), 32'd0);
        run(7'h10, 3, 1'b0);
        chk("rf_early_valid", 32'(b1.out_valid), 32'd0);
        step(7'h10, 1'b1, 1'b0);
        chk("rf_new_valid", 32'(b1.out_valid), 32'd1);
        chk("rf_new_value", 32'(b1.out_value), 32'd9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
